// File: rtl/exec_run_control.sv
// -----------------------------------------------------------------------------
// exec_run_control
//   Run / single-step / halt front end for the multi-phase CPU sequencer.
//   Conditions the raw exec pushbutton (2-flop sync, counter debounce,
//   one-cycle press pulse) and drives the phase controller's exectrue gate.
//   The gate only changes on a clock edge where the controller's counter code
//   equals END_PHASE, so an instruction's clock0..clock4 pulses are never cut.
//   Completed gated instructions are counted for the status display.
//
// Ports
//   clock        in   1   system clock, shared with the phase controller
//   reset_n      in   1   asynchronous active-low reset
//   execbutton   in   1   raw pushbutton, active-high, asynchronous
//   stepmode     in   1   slide switch, asynchronous; 1 = single-step
//   haltin       in   1   halt request from the CPU, synchronous (level/pulse)
//   counterin    in   5   controller counter code
//   exectrue     out  1   registered phase-pulse gate
//   runstate     out  3   state code for LEDs
//   instr_count  out  16  completed gated instructions (wraps)
// -----------------------------------------------------------------------------
module exec_run_control #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [4:0]  END_PHASE       = 5'd21
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        execbutton,
    input  logic        stepmode,
    input  logic        haltin,
    input  logic [4:0]  counterin,
    output logic        exectrue,
    output logic [2:0]  runstate,
    output logic [15:0] instr_count
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_ARM_RUN  = 3'd1,
        S_RUN      = 3'd2,
        S_STOPPING = 3'd3,
        S_ARM_STEP = 3'd4,
        S_STEP     = 3'd5,
        S_HALTED   = 3'd6
    } state_e;

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic btn_meta_q,  btn_sync_q;
    logic step_meta_q, step_sync_q;

    // Two-flop synchronizers for the asynchronous button and switch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
        end else begin
            btn_meta_q  <= execbutton;
            btn_sync_q  <= btn_meta_q;
            step_meta_q <= stepmode;
            step_sync_q <= step_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             stable_q, stable_d;
    logic             press_q,  press_d;

    // Counter runs only while the synced level differs from the accepted one;
    // any return to the accepted level restarts the qualification window.
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (btn_sync_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 16'd1)) begin
            stable_d = btn_sync_q;
            db_cnt_d = '0;
            press_d  = btn_sync_q;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    // Debounce state; press is registered alongside the accepted level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_q <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    // -------------------------------------------------------------------------
    // Run control state machine
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic             exectrue_q, exectrue_d;
    logic             halt_pending_q, halt_pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             is_end;
    logic             halt_now;

    assign is_end   = (counterin == END_PHASE);
    assign halt_now = halt_pending_q | haltin;

    // Next state, gate and bookkeeping; every gate change is qualified by is_end
    always_comb begin
        state_d        = state_q;
        exectrue_d     = exectrue_q;
        halt_pending_d = halt_pending_q;
        count_d        = count_q;

        // Halt requests are only remembered once a run or step is under way
        if (haltin && (state_q inside {S_ARM_RUN, S_RUN, S_STOPPING,
                                       S_ARM_STEP, S_STEP})) begin
            halt_pending_d = 1'b1;
        end

        if (is_end && exectrue_q) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                exectrue_d = 1'b0;
                if (press_q) begin
                    state_d = step_sync_q ? S_ARM_STEP : S_ARM_RUN;
                end
            end
            S_ARM_RUN: begin
                if (is_end) begin
                    state_d    = S_RUN;
                    exectrue_d = 1'b1;
                end
            end
            S_ARM_STEP: begin
                if (is_end) begin
                    state_d    = S_STEP;
                    exectrue_d = 1'b1;
                end
            end
            S_RUN: begin
                // Halt at the boundary wins over a stop request
                if (is_end && halt_now) begin
                    state_d    = S_HALTED;
                    exectrue_d = 1'b0;
                end else if (press_q) begin
                    state_d = S_STOPPING;
                end
            end
            S_STOPPING, S_STEP: begin
                if (is_end) begin
                    state_d    = halt_pending_q ? S_HALTED : S_IDLE;
                    exectrue_d = 1'b0;
                end
            end
            S_HALTED: begin
                exectrue_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                exectrue_d = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            exectrue_q     <= 1'b0;
            halt_pending_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            exectrue_q     <= exectrue_d;
            halt_pending_q <= halt_pending_d;
            count_q        <= count_d;
        end
    end

    assign exectrue    = exectrue_q;
    assign runstate    = state_q;
    assign instr_count = count_q;

`ifndef SYNTHESIS
    // Gate may only move on an instruction boundary
    a_gate_on_boundary : assert property (@(posedge clock) disable iff (!reset_n)
        !is_end |=> $stable(exectrue_q));

    // HALTED is left only through reset
    a_halted_sticky : assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == S_HALTED) |=> (state_q == S_HALTED));
`endif

endmodule

// File: tb/tb_exec_run_control.sv
// -----------------------------------------------------------------------------
// tb_exec_run_control
//   Directed vector table, hand-written corner sequences and randomized
//   stimulus for exec_run_control, checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_exec_run_control;

    localparam logic [15:0] DB   = 16'd4;
    localparam logic [4:0]  ENDP = 5'd21;
    localparam int          DBI  = 4;

    logic        clock;
    logic        reset_n;
    logic        execbutton;
    logic        stepmode;
    logic        haltin;
    logic [4:0]  counterin;
    logic        exectrue;
    logic [2:0]  runstate;
    logic [15:0] instr_count;

    exec_run_control #(
        .DEBOUNCE_CYCLES (DB),
        .END_PHASE       (ENDP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .execbutton  (execbutton),
        .stepmode    (stepmode),
        .haltin      (haltin),
        .counterin   (counterin),
        .exectrue    (exectrue),
        .runstate    (runstate),
        .instr_count (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Phase controller counter sequence
    logic [4:0] seq [10];
    int         idx;
    bit         stall;

    // Behavioural model
    bit          m_b1, m_b2, m_s1, m_s2;
    bit          winq [$];
    bit          m_stable, m_press;
    int          m_state;
    bit          m_halt;
    logic [15:0] m_count;

    function automatic bit m_gate();
        return (m_state == 2) || (m_state == 3) || (m_state == 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0;
        m_stable = 0; m_press = 0;
        m_state = 0; m_halt = 0; m_count = 16'd0;
        winq = {};
        for (int i = 0; i < DBI; i++) winq.push_back(1'b0);
    endtask

    // One rising edge of the model, using the inputs present at that edge
    task automatic model_edge();
        bit e, g_old, hp_old, all_diff;
        int ns;
        e      = (counterin == ENDP);
        g_old  = m_gate();
        hp_old = m_halt;
        ns     = m_state;
        case (m_state)
            0: if (m_press) ns = m_s2 ? 4 : 1;
            1: if (e) ns = 2;
            4: if (e) ns = 5;
            2: begin
                if (e && (hp_old || haltin)) ns = 6;
                else if (m_press) ns = 3;
            end
            3, 5: if (e) ns = hp_old ? 6 : 0;
            default: ;
        endcase
        if (haltin && (m_state >= 1) && (m_state <= 5)) m_halt = 1;
        if (e && g_old) m_count = m_count + 16'd1;
        m_state = ns;
        // A new level is accepted once the last DB synced samples all differ
        winq.push_back(m_b2);
        if (winq.size() > DBI) void'(winq.pop_front());
        all_diff = 1;
        foreach (winq[i]) if (winq[i] == m_stable) all_diff = 0;
        m_press = 0;
        if (all_diff) begin
            m_stable = ~m_stable;
            m_press  = m_stable;
        end
        m_b2 = m_b1; m_b1 = execbutton;
        m_s2 = m_s1; m_s1 = stepmode;
    endtask

    task automatic advance_counter();
        if (!stall) idx = (idx + 1) % 10;
        counterin = seq[idx];
    endtask

    // One clock: model the edge, check outputs, then move the counter
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("runstate", 32'(runstate), 32'(m_state));
        check("exectrue", 32'(exectrue), 32'(m_gate()));
        check("instr_count", 32'(instr_count), 32'(m_count));
        advance_counter();
    endtask

    // Assert reset now, verify outputs cleared before any edge, release later
    task automatic hold_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_exectrue"}, 32'(exectrue), 32'd0);
        check({tag, "_runstate"}, 32'(runstate), 32'd0);
        check({tag, "_instr_count"}, 32'(instr_count), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        advance_counter();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != st && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_reached"}, 32'(runstate), 32'(st));
    endtask

    typedef struct {
        int          cycles;
        bit          btn;
        bit          step;
        bit          halt;
        logic [2:0]  st;
        bit          gate;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int btn_hold, stall_len;
        logic [15:0] cnt_before;

        seq = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd4, 5'd12, 5'd8, 5'd24, 5'd21};

        // Bounce: 1/0 every 2 clocks for 20 clocks, nothing accepted
        for (int i = 0; i < 10; i++) tbl.push_back('{2, (i % 2) == 0, 0, 0, 3'd0, 0, 16'd0});
        tbl.push_back('{8,  1, 0, 0, 3'd1, 0, 16'd0});   // held: one press -> ARM_RUN
        tbl.push_back('{2,  1, 0, 0, 3'd2, 1, 16'd0});   // boundary -> RUN
        tbl.push_back('{30, 0, 0, 0, 3'd2, 1, 16'd3});   // one count per 10 clocks
        tbl.push_back('{7,  1, 0, 0, 3'd3, 1, 16'd3});   // press at code 12 -> STOPPING
        tbl.push_back('{2,  1, 0, 0, 3'd3, 1, 16'd3});   // gate held until boundary
        tbl.push_back('{11, 1, 0, 0, 3'd0, 0, 16'd4});   // boundary -> IDLE
        tbl.push_back('{10, 0, 0, 0, 3'd0, 0, 16'd4});
        for (int k = 0; k < 2; k++) begin              // two single steps
            tbl.push_back('{7, 1, 1, 0, 3'd4, 0, 16'(4 + k)});
            tbl.push_back('{3, 1, 1, 0, 3'd5, 1, 16'(4 + k)});
            tbl.push_back('{9, 0, 1, 0, 3'd5, 1, 16'(4 + k)});
            tbl.push_back('{1, 0, 1, 0, 3'd0, 0, 16'(5 + k)});
        end
        tbl.push_back('{10, 1, 0, 0, 3'd2, 1, 16'd6});   // run again
        tbl.push_back('{10, 0, 0, 0, 3'd2, 1, 16'd7});
        tbl.push_back('{2,  0, 0, 0, 3'd2, 1, 16'd7});
        tbl.push_back('{1,  0, 0, 1, 3'd2, 1, 16'd7});   // 1-cycle halt at code 3
        tbl.push_back('{7,  0, 0, 0, 3'd6, 0, 16'd8});   // HALTED at next boundary
        tbl.push_back('{20, 1, 0, 0, 3'd6, 0, 16'd8});   // press ignored
        tbl.push_back('{10, 0, 0, 0, 3'd6, 0, 16'd8});

        // Power-on reset
        reset_n = 1'b0; execbutton = 1'b0; stepmode = 1'b0; haltin = 1'b0;
        stall = 0; idx = 0; counterin = seq[0];
        model_reset();
        #1;
        check("por_exectrue", 32'(exectrue), 32'd0);
        check("por_runstate", 32'(runstate), 32'd0);
        check("por_instr_count", 32'(instr_count), 32'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;

        // Directed vector table
        foreach (tbl[i]) begin
            execbutton = tbl[i].btn;
            stepmode   = tbl[i].step;
            haltin     = tbl[i].halt;
            repeat (tbl[i].cycles) cycle();
            check($sformatf("vec%0d_runstate", i), 32'(runstate), 32'(tbl[i].st));
            check($sformatf("vec%0d_exectrue", i), 32'(exectrue), 32'(tbl[i].gate));
            check($sformatf("vec%0d_instr_count", i), 32'(instr_count), 32'(tbl[i].cnt));
        end
        haltin = 1'b0;

        // Reset out of HALTED
        hold_reset("halt_reset");

        // Stalled controller: count advances every cycle while gated
        execbutton = 1'b1; stepmode = 1'b0;
        repeat (8) cycle();
        execbutton = 1'b0;
        wait_state(2, 40, "stall_run");
        while (idx != 9) cycle();
        stall = 1;
        cnt_before = instr_count;
        repeat (5) cycle();
        check("stall_count", 32'(instr_count), 32'(cnt_before + 16'd5));
        check("stall_state", 32'(runstate), 32'd2);
        stall = 0;
        repeat (3) cycle();

        // Async reset in the middle of a RUN instruction at code 24
        begin
            int n;
            n = 0;
            while (counterin != 5'd24 && n < 20) begin
                cycle();
                n++;
            end
            check("mid_run_code", 32'(counterin), 32'd24);
            check("mid_run_gate", 32'(exectrue), 32'd1);
            #3;
            hold_reset("async_reset");
        end

        // Randomized stimulus
        btn_hold = 0; stall_len = 0;
        for (int c = 0; c < 3000; c++) begin
            if (btn_hold == 0) begin
                execbutton = 1'($urandom_range(0, 1));
                btn_hold   = int'($urandom_range(1, 12));
            end
            btn_hold--;
            if ($urandom_range(0, 63) == 0) stepmode = ~stepmode;
            haltin = ($urandom_range(0, 299) == 0);
            if (stall) begin
                stall_len--;
                if (stall_len == 0) stall = 0;
            end else if (idx == 9 && $urandom_range(0, 19) == 0) begin
                stall     = 1;
                stall_len = int'($urandom_range(1, 6));
            end
            cycle();
            if ((c % 400) == 399) begin
                haltin = 1'b0;
                stall  = 0;
                hold_reset("rand_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
